// File: rtl/dct_mac_sequencer.sv
// Sequencer for one fdct multiply-accumulate lane: counts taps into the MAC,
// then presents each finished dot product while tracking the row within the 8x8 block.
//
//  state | meaning
//  ------+---------------------------------------------------------------
//  ACC   | accepting samples, issuing coefficient index and mult enable
//  LAST  | last product is being accumulated, input held off
//  OUT   | accumulator holds a result, waiting for downstream handshake
module dct_mac_sequencer #(
    parameter int TAPS  = 8,
    parameter int TAP_W = 3,
    parameter int VECS  = 8,
    parameter int VEC_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [TAP_W-1:0] coef_idx,
    output logic             mult_en,
    output logic             acc_en,
    output logic             acc_load,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [VEC_W-1:0] row_idx,
    output logic             block_last,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_ACC  = 2'd0,
        ST_LAST = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [TAP_W-1:0] tap_cnt;
    logic             accept;
    logic             tap_last;
    logic             out_hs;

    assign tap_last = (tap_cnt == TAP_W'(TAPS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_ACC;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = ST_ACC;
        end else begin
            case (state)
                ST_ACC:  if (accept && tap_last) state_nxt = ST_LAST;
                ST_LAST: state_nxt = ST_OUT;
                ST_OUT:  if (dout_ready) state_nxt = ST_ACC;
                default: state_nxt = ST_ACC;
            endcase
        end
    end

    // Outputs decode from the registered state, so dout_valid is glitch-free
    // and drops with the async reset without waiting for an edge.
    always_comb begin
        din_ready  = (state == ST_ACC) && !rst && !flush;
        dout_valid = (state == ST_OUT);
        accept     = din_valid && din_ready;
        mult_en    = accept;
        coef_idx   = tap_cnt;
        out_hs     = dout_valid && dout_ready;
        block_last = dout_valid && (row_idx == VEC_W'(VECS - 1));
        busy       = (state != ST_ACC) || (tap_cnt != '0) || (row_idx != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tap_cnt  <= '0;
            row_idx  <= '0;
            acc_en   <= 1'b0;
            acc_load <= 1'b0;
        end else if (flush) begin
            tap_cnt  <= '0;
            row_idx  <= '0;
            acc_en   <= 1'b0;
            acc_load <= 1'b0;
        end else begin
            acc_en   <= accept;
            acc_load <= accept && (tap_cnt == '0);
            if (accept) begin
                tap_cnt <= tap_last ? '0 : tap_cnt + 1'b1;
            end
            if (out_hs) begin
                row_idx <= (row_idx == VEC_W'(VECS - 1)) ? '0 : row_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dct_mac_sequencer.sv
// Directed bench for dct_mac_sequencer: vectors with gaps, backpressure,
// a full block, flush and asynchronous reset, against hand-derived timing.
module tb_dct_mac_sequencer;

    localparam int TAPS  = 8;
    localparam int TAP_W = 3;
    localparam int VECS  = 8;
    localparam int VEC_W = 3;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             din_valid;
    logic             din_ready;
    logic [TAP_W-1:0] coef_idx;
    logic             mult_en;
    logic             acc_en;
    logic             acc_load;
    logic             dout_valid;
    logic             dout_ready;
    logic [VEC_W-1:0] row_idx;
    logic             block_last;
    logic             busy;

    int checks = 0;
    int errors = 0;

    dct_mac_sequencer #(
        .TAPS (TAPS),
        .TAP_W(TAP_W),
        .VECS (VECS),
        .VEC_W(VEC_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .coef_idx  (coef_idx),
        .mult_en   (mult_en),
        .acc_en    (acc_en),
        .acc_load  (acc_load),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .row_idx   (row_idx),
        .block_last(block_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One vector: optional input gap before tap gap_at, bp_len cycles of
    // dout_ready=0 in OUT, then the handshake unless hs=0.
    task automatic do_vec(input int row, input int gap_at, input int gap_len,
                          input int bp_len, input bit hs);
        bit pa;
        bit p0;
        pa = 1'b0;
        p0 = 1'b0;
        dout_ready = (bp_len == 0);
        for (int t = 0; t < TAPS; t++) begin
            if (t == gap_at) begin
                din_valid = 1'b0;
                for (int g = 0; g < gap_len; g++) begin
                    #1;
                    chk("gap_coef_idx", int'(coef_idx), t);
                    chk("gap_mult_en", int'(mult_en), 0);
                    chk("gap_acc_en", int'(acc_en), int'(pa));
                    chk("gap_acc_load", int'(acc_load), 0);
                    tick();
                    pa = 1'b0;
                    p0 = 1'b0;
                end
            end
            din_valid = 1'b1;
            #1;
            chk("coef_idx", int'(coef_idx), t);
            chk("mult_en", int'(mult_en), 1);
            chk("acc_en", int'(acc_en), int'(pa));
            chk("acc_load", int'(acc_load), int'(pa & p0));
            chk("tap_row_idx", int'(row_idx), row);
            chk("tap_busy", int'(busy), int'((t != 0) || (row != 0)));
            tick();
            pa = 1'b1;
            p0 = (t == 0);
        end
        // din_valid held high through LAST must be ignored
        #1;
        chk("last_din_ready", int'(din_ready), 0);
        chk("last_mult_en", int'(mult_en), 0);
        chk("last_acc_en", int'(acc_en), 1);
        chk("last_acc_load", int'(acc_load), 0);
        chk("last_dout_valid", int'(dout_valid), 0);
        tick();
        din_valid = 1'b0;
        for (int b = 0; b < bp_len; b++) begin
            #1;
            chk("bp_dout_valid", int'(dout_valid), 1);
            chk("bp_din_ready", int'(din_ready), 0);
            chk("bp_row_idx", int'(row_idx), row);
            chk("bp_block_last", int'(block_last), int'(row == VECS - 1));
            tick();
        end
        if (hs) begin
            dout_ready = 1'b1;
            #1;
            chk("out_dout_valid", int'(dout_valid), 1);
            chk("out_acc_en", int'(acc_en), 0);
            chk("out_row_idx", int'(row_idx), row);
            chk("out_block_last", int'(block_last), int'(row == VECS - 1));
            tick();
            dout_ready = 1'b0;
            #1;
            chk("post_din_ready", int'(din_ready), 1);
            chk("post_dout_valid", int'(dout_valid), 0);
            chk("post_row_idx", int'(row_idx), (row + 1) % VECS);
        end
    endtask

    initial begin
        rst        = 1'b1;
        flush      = 1'b0;
        din_valid  = 1'b1;
        dout_ready = 1'b0;
        #2;
        chk("rst_din_ready", int'(din_ready), 0);
        chk("rst_mult_en", int'(mult_en), 0);
        chk("rst_dout_valid", int'(dout_valid), 0);
        chk("rst_acc_en", int'(acc_en), 0);
        chk("rst_coef_idx", int'(coef_idx), 0);
        chk("rst_row_idx", int'(row_idx), 0);
        tick();
        tick();
        din_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("idle_busy", int'(busy), 0);
        chk("idle_din_ready", int'(din_ready), 1);

        // Full block: back-to-back, gapped, backpressured, then plain rows
        do_vec(0, -1, 0, 0, 1'b1);
        do_vec(1, 4, 3, 0, 1'b1);
        do_vec(2, -1, 0, 5, 1'b1);
        for (int r = 3; r < VECS; r++) do_vec(r, -1, 0, 0, 1'b1);
        chk("block_wrap_row", int'(row_idx), 0);
        chk("block_idle_busy", int'(busy), 0);

        // Flush at tap 5 of row 2
        do_vec(0, -1, 0, 0, 1'b1);
        do_vec(1, -1, 0, 0, 1'b1);
        din_valid = 1'b1;
        for (int t = 0; t < 5; t++) tick();
        #1;
        chk("pre_flush_coef", int'(coef_idx), 5);
        flush = 1'b1;
        #1;
        chk("flush_din_ready", int'(din_ready), 0);
        chk("flush_mult_en", int'(mult_en), 0);
        tick();
        flush = 1'b0;
        din_valid = 1'b0;
        #1;
        chk("flush_coef_idx", int'(coef_idx), 0);
        chk("flush_row_idx", int'(row_idx), 0);
        chk("flush_acc_en", int'(acc_en), 0);
        chk("flush_dout_valid", int'(dout_valid), 0);
        chk("flush_busy", int'(busy), 0);
        do_vec(0, -1, 0, 0, 1'b1);

        // Async reset while a result waits in OUT
        do_vec(1, -1, 0, 2, 1'b0);
        #1;
        chk("pre_rst_dout_valid", int'(dout_valid), 1);
        rst = 1'b1;
        #1;
        chk("arst_dout_valid", int'(dout_valid), 0);
        chk("arst_din_ready", int'(din_ready), 0);
        chk("arst_acc_en", int'(acc_en), 0);
        tick();
        rst = 1'b0;
        dout_ready = 1'b0;
        #1;
        chk("rel_coef_idx", int'(coef_idx), 0);
        chk("rel_row_idx", int'(row_idx), 0);
        chk("rel_din_ready", int'(din_ready), 1);

        // Async reset mid-vector while acc_en is high
        din_valid = 1'b1;
        tick();
        tick();
        #1;
        chk("mid_acc_en", int'(acc_en), 1);
        chk("mid_coef_idx", int'(coef_idx), 2);
        rst = 1'b1;
        #1;
        chk("mid_rst_acc_en", int'(acc_en), 0);
        chk("mid_rst_mult_en", int'(mult_en), 0);
        chk("mid_rst_coef_idx", int'(coef_idx), 0);
        tick();
        rst = 1'b0;
        din_valid = 1'b0;
        do_vec(0, -1, 0, 0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
